// File: rtl/btn_load_conditioner_pkg.sv
// Shared definitions for the operand-load button conditioner.
// Debouncer state encoding and the board default debounce length.
package btn_load_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } dbn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF sync, debounce FSM, registered
// one-shot load pulse and debounced held level.
module btn_debounce
  import btn_load_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic load,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  dbn_state_t       state;
  dbn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             s1;
  logic             s2;
  logic             load_nxt;
  logic             held_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      held  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      load  <= load_nxt;
      held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_nxt  = 1'b0;
    held_nxt  = held;
    unique case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          load_nxt  = 1'b1;
          held_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end
      end
      REL_CHK: begin
        // a high sample here is release bounce
        if (s2) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          held_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/btn_load_conditioner.sv
// Conditions the two raw load buttons into one-cycle
// operand-register load pulses; wiring only.
module btn_load_conditioner
  import btn_load_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btnLoadA,
  input  logic btnLoadB,
  output logic loadA,
  output logic loadB,
  output logic heldA,
  output logic heldB
);

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbn_a (
    .clk (clk),
    .rst (rst),
    .btn (btnLoadA),
    .load(loadA),
    .held(heldA)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbn_b (
    .clk (clk),
    .rst (rst),
    .btn (btnLoadB),
    .load(loadB),
    .held(heldB)
  );

endmodule

// File: tb/tb_btn_load_conditioner.sv
// Bench for btn_load_conditioner with a run-length reference
// model plus directed latency/glitch/bounce/reset scenarios.
module tb_btn_load_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic btnLoadA;
  logic btnLoadB;
  logic loadA;
  logic loadB;
  logic heldA;
  logic heldB;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_s1[2];
  bit m_s2[2];
  bit m_held[2];
  bit m_load[2];
  int m_run[2];

  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  btn_load_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btnLoadA(btnLoadA),
    .btnLoadB(btnLoadB),
    .loadA   (loadA),
    .loadB   (loadB),
    .heldA   (heldA),
    .heldB   (heldB)
  );

  task automatic check(input string tag, input int obs,
                       input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  // Model: a press is accepted after D+1 consecutive high
  // synchronized samples while released; release likewise
  // needs D+1 consecutive lows while held.
  task automatic model_step(input bit r, input bit b0,
                            input bit b1);
    bit b[2];
    b[0] = b0;
    b[1] = b1;
    for (int c = 0; c < 2; c++) begin
      if (r) begin
        m_s1[c] = 0; m_s2[c] = 0; m_held[c] = 0;
        m_load[c] = 0; m_run[c] = 0;
      end else begin
        m_load[c] = 0;
        if (m_s2[c] != m_held[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == D + 1) begin
          m_run[c]  = 0;
          m_held[c] = !m_held[c];
          m_load[c] = m_held[c];
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = b[c];
      end
    end
  endtask

  task automatic tick();
    bit r, b0, b1;
    r  = rst;
    b0 = btnLoadA;
    b1 = btnLoadB;
    @(posedge clk);
    model_step(r, b0, b1);
    #1;
    check("loadA", int'(loadA), int'(m_load[0]));
    check("loadB", int'(loadB), int'(m_load[1]));
    check("heldA", int'(heldA), int'(m_held[0]));
    check("heldB", int'(heldB), int'(m_held[1]));
    if (loadA === 1'b1) pulses_a++;
    if (loadB === 1'b1) pulses_b++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      btnLoadA = i[0];
      btnLoadB = !i[0];
      tick();
      check("rst_loadA", int'(loadA), 0);
      check("rst_heldB", int'(heldB), 0);
    end
    rst = 1'b0;
    btnLoadA = 1'b0;
    btnLoadB = 1'b0;
  endtask

  task automatic idle(input int n);
    btnLoadA = 1'b0;
    btnLoadB = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first_a, first_b, both, pa, pb;
    int rem_a, rem_b;
    rst = 1'b1;
    btnLoadA = 1'b0;
    btnLoadB = 1'b0;

    do_reset(2);
    idle(3);
    check("post_rst_held", int'(heldA | heldB), 0);

    // clean press on A from edge 0
    first_a = -1;
    pb = pulses_b;
    pa = pulses_a;
    btnLoadA = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (loadA === 1'b1 && first_a < 0) first_a = i;
      if (i == 5) check("clean_held_pre", int'(heldA), 0);
      if (i == 6) check("clean_held_on", int'(heldA), 1);
    end
    check("clean_lat", first_a, 6);
    check("clean_once", pulses_a - pa, 1);
    check("clean_no_b", pulses_b - pb, 0);
    check("clean_held", int'(heldA), 1);

    // release with 0,1,0 bounce
    pa = pulses_a;
    btnLoadA = 1'b0; tick();
    btnLoadA = 1'b1; tick();
    btnLoadA = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rel_still_held", int'(heldA), 1);
    for (int i = 0; i < 4; i++) tick();
    check("rel_held_off", int'(heldA), 0);
    check("rel_no_pulse", pulses_a - pa, 0);
    idle(3);

    // glitch on B
    pb = pulses_b;
    btnLoadB = 1'b1; tick(); tick();
    btnLoadB = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch_heldB", int'(heldB), 0);
    end
    check("glitch_no_pulse", pulses_b - pb, 0);

    // press bounce 1,0,1,0,1 then steady high
    pa = pulses_a;
    for (int i = 0; i < 5; i++) begin
      btnLoadA = ~i[0];
      tick();
    end
    btnLoadA = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    btnLoadA = 1'b0; tick();
    btnLoadA = 1'b1; tick();
    btnLoadA = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("bounce_once", pulses_a - pa, 1);
    check("bounce_held_off", int'(heldA), 0);

    // simultaneous A and B
    first_a = -1; first_b = -1; both = 0;
    btnLoadA = 1'b1;
    btnLoadB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (loadA === 1'b1 && first_a < 0) first_a = i;
      if (loadB === 1'b1 && first_b < 0) first_b = i;
      if (loadA === 1'b1 && loadB === 1'b1) both++;
    end
    check("sim_lat_a", first_a, 6);
    check("sim_lat_b", first_b, 6);
    check("sim_same", both, 1);
    idle(12);

    // reset mid-press, button kept high
    pa = pulses_a;
    btnLoadA = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_no_pulse", pulses_a - pa, 0);
    rst = 1'b1; tick();
    rst = 1'b0;
    btnLoadA = 1'b1;
    first_a = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (loadA === 1'b1 && first_a < 0) first_a = i;
    end
    check("mid_lat", first_a, 6);
    check("mid_once", pulses_a - pa, 1);
    idle(12);

    // randomized bursty stimulus
    rem_a = 0;
    rem_b = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rem_a == 0) begin
        btnLoadA = 1'($urandom_range(0, 1));
        rem_a = $urandom_range(1, 9);
      end
      if (rem_b == 0) begin
        btnLoadB = 1'($urandom_range(0, 1));
        rem_b = $urandom_range(1, 9);
      end
      rem_a--;
      rem_b--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
